font_banner_ctrl: RTL and testbench

//  Sequences the 320x50 text-banner font ROM, e.g. "READY" or "GAME OVER".

---
 rtl/font_banner_ctrl.sv | 158 +++++++++++++++
 tb/tb_font_banner_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/font_banner_ctrl.sv
// font_banner_ctrl
// Drives the text-banner font ROM from the VGA raster counters. The ROM
// address comes from a row base and a column counter, so no per-pixel
// multiply is needed. Show/hide/blink commands wait in a one-deep pending
// slot. They take effect only at the apply line, so a banner never tears.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  OFF    | banner hidden; the address still tracks the raster
//  SHOW   | banner visible in every frame
//  BLINK  | banner visible while phase_on; the phase flips every
//         | BLINK_FRAMES frames
module font_banner_ctrl #(
  parameter int X0           = 160,
  parameter int Y0           = 390,
  parameter int W            = 320,
  parameter int H            = 50,
  parameter int APPLY_LINE   = 480,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_banner,
  output logic        cmd_ready,
  output logic [13:0] font_pixel_addr,
  output logic [1:0]  font_bank,
  output logic        font_en
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLINK = 2'd2;

  localparam logic [1:0] OP_SHOW  = 2'b01;
  localparam logic [1:0] OP_BLINK = 2'b10;

  localparam logic [9:0] H_LO    = 10'(X0);
  localparam logic [9:0] H_HI    = 10'(X0 + W - 1);
  localparam logic [9:0] H_END   = 10'(X0 + W);
  localparam logic [9:0] V_LO    = 10'(Y0);
  localparam logic [9:0] V_HI    = 10'(Y0 + H - 1);
  // The last banner row never advances row_base, so row_base tops out at (H-1)*W.
  localparam logic [9:0] V_STEP  = 10'(Y0 + H - 2);
  localparam logic [9:0] V_APPLY = 10'(APPLY_LINE);
  localparam logic [13:0] ROW_STEP = 14'(W);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [1:0]    state;
  logic [1:0]    pend_op;
  logic [1:0]    pend_bank;
  logic [BW-1:0] blink_cnt;
  logic          phase_on;
  logic [13:0]   row_base;
  logic [13:0]   col_cnt;

  logic          h_in;
  logic          v_in;
  logic          win;
  logic          apply_pt;
  logic          accept;
  logic          visible;
  logic          row_start;
  logic          row_step;
  logic [13:0]   col_cur;

  // Raster decode: window membership, apply point, counter events.
  always_comb begin
    h_in      = (h_cnt >= H_LO) && (h_cnt <= H_HI);
    v_in      = (v_cnt >= V_LO) && (v_cnt <= V_HI);
    win       = h_in && v_in;
    apply_pt  = (v_cnt == V_APPLY) && (h_cnt == 10'd0);
    accept    = cmd_valid && cmd_ready;
    row_start = (v_cnt == V_LO) && (h_cnt == 10'd0);
    row_step  = (h_cnt == H_END) && (v_cnt >= V_LO) && (v_cnt <= V_STEP);
    // The first window column restarts at zero, whatever the counter held.
    col_cur   = (h_cnt == H_LO) ? 14'd0 : col_cnt;
    visible   = (state == ST_SHOW) || ((state == ST_BLINK) && phase_on);
  end

  // Row base: cleared at the first banner row start, advanced by W after each row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base <= 14'd0;
    end else if (row_start) begin
      row_base <= 14'd0;
    end else if (row_step) begin
      row_base <= row_base + ROW_STEP;
    end
  end

  // Column counter: runs across the window and idles at zero outside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= 14'd0;
    end else if (win) begin
      col_cnt <= col_cur + 14'd1;
    end else begin
      col_cnt <= 14'd0;
    end
  end

  // Registered ROM address and pixel enable, one cycle behind the raster.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      font_pixel_addr <= 14'd0;
      font_en         <= 1'b0;
    end else begin
      font_pixel_addr <= win ? (row_base + col_cur) : 14'd0;
      font_en         <= win && visible;
    end
  end

  // Command slot, state machine and blink timer. Everything moves at the apply point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_OFF;
      font_bank <= 2'd0;
      cmd_ready <= 1'b1;
      pend_op   <= 2'b00;
      pend_bank <= 2'd0;
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (apply_pt && !cmd_ready) begin
      font_bank <= pend_bank;
      cmd_ready <= 1'b1;
      case (pend_op)
        OP_SHOW: state <= ST_SHOW;
        OP_BLINK: begin
          state     <= ST_BLINK;
          blink_cnt <= '0;
          phase_on  <= 1'b1;
        end
        default: state <= ST_OFF;
      endcase
    end else begin
      if (accept) begin
        pend_op   <= cmd_op;
        pend_bank <= cmd_banner;
        cmd_ready <= 1'b0;
      end
      if (apply_pt && (state == ST_BLINK)) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          phase_on  <= ~phase_on;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_font_banner_ctrl.sv
// Testbench for font_banner_ctrl: directed raster sweeps and commands.
// Expected responses are queued, tagged with the cycle they should appear.
// A negedge monitor pops and compares them.
module tb_font_banner_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_banner;
  logic        cmd_ready;
  logic [13:0] font_pixel_addr;
  logic [1:0]  font_bank;
  logic        font_en;

  font_banner_ctrl #(.BLINK_FRAMES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .h_cnt           (h_cnt),
    .v_cnt           (v_cnt),
    .cmd_valid       (cmd_valid),
    .cmd_op          (cmd_op),
    .cmd_banner      (cmd_banner),
    .cmd_ready       (cmd_ready),
    .font_pixel_addr (font_pixel_addr),
    .font_bank       (font_bank),
    .font_en         (font_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mask bits: [3] font_en, [2] addr, [1] bank, [0] cmd_ready
  localparam logic [3:0] M_ALL = 4'b1111;
  localparam logic [3:0] M_EA  = 4'b1100;
  localparam logic [3:0] M_EN  = 4'b1000;
  localparam logic [3:0] M_AD  = 4'b0100;
  localparam logic [3:0] M_BR  = 4'b0011;
  localparam logic [3:0] M_BK  = 4'b0010;
  localparam logic [3:0] M_RD  = 4'b0001;

  int          q_cyc[$];
  logic [3:0]  q_mask[$];
  logic        q_en[$];
  logic [13:0] q_addr[$];
  logic [1:0]  q_bank[$];
  logic        q_rdy[$];
  string       q_name[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor: compare every expectation due in this cycle against the DUT outputs.
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      n_checks++;
      if (q_cyc[0] < cyc) begin
        $display("FAIL %s: expectation for cycle %0d left unchecked at cycle %0d",
                 q_name[0], q_cyc[0], cyc);
      end else if ((q_mask[0][3] && font_en !== q_en[0]) ||
                   (q_mask[0][2] && font_pixel_addr !== q_addr[0]) ||
                   (q_mask[0][1] && font_bank !== q_bank[0]) ||
                   (q_mask[0][0] && cmd_ready !== q_rdy[0])) begin
        $display("FAIL %s (mask %b): got en=%0b addr=%0d bank=%0d rdy=%0b, want en=%0b addr=%0d bank=%0d rdy=%0b",
                 q_name[0], q_mask[0], font_en, font_pixel_addr, font_bank, cmd_ready,
                 q_en[0], q_addr[0], q_bank[0], q_rdy[0]);
      end else begin
        n_pass++;
      end
      void'(q_cyc.pop_front());
      void'(q_mask.pop_front());
      void'(q_en.pop_front());
      void'(q_addr.pop_front());
      void'(q_bank.pop_front());
      void'(q_rdy.pop_front());
      void'(q_name.pop_front());
    end
  end

  task automatic push(input string nm, input logic [3:0] m, input logic e,
                      input logic [13:0] a, input logic [1:0] b, input logic r,
                      input int dly);
    q_cyc.push_back(cyc + dly);
    q_mask.push_back(m);
    q_en.push_back(e);
    q_addr.push_back(a);
    q_bank.push_back(b);
    q_rdy.push_back(r);
    q_name.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_win(input int h, input int v);
    return (h >= 160) && (h <= 479) && (v >= 390) && (v <= 439);
  endfunction

  function automatic logic [13:0] model_addr(input int h, input int v);
    if (in_win(h, v)) return 14'((h - 160) + (v - 390) * 320);
    return 14'd0;
  endfunction

  task automatic sweep(input int v, input int h0, input int h1, input logic vis,
                       input logic [3:0] m);
    for (int h = h0; h <= h1; h++) begin
      h_cnt = 10'(h);
      v_cnt = 10'(v);
      push($sformatf("pix_%0d_%0d", h, v), m, in_win(h, v) && vis, model_addr(h, v),
           2'd0, 1'b0, 1);
      if (m[2]) begin
        if (h == 160 && v == 390) push("addr_first_0", M_AD, 1'b0, 14'd0, 2'd0, 1'b0, 1);
        if (h == 479 && v == 390) push("addr_row0_end_319", M_AD, 1'b0, 14'd319, 2'd0, 1'b0, 1);
        if (h == 160 && v == 391) push("addr_row1_start_320", M_AD, 1'b0, 14'd320, 2'd0, 1'b0, 1);
        if (h == 479 && v == 439) push("addr_last_15999", M_AD, 1'b0, 14'd15999, 2'd0, 1'b0, 1);
      end
      if (h == 159 && v == 390) push("en_h159", M_EN, 1'b0, 14'd0, 2'd0, 1'b0, 1);
      if (h == 480 && v == 390) push("en_h480", M_EN, 1'b0, 14'd0, 2'd0, 1'b0, 1);
      if (h == 200 && v == 389) push("en_v389", M_EN, 1'b0, 14'd0, 2'd0, 1'b0, 1);
      if (h == 200 && v == 440) push("en_v440", M_EN, 1'b0, 14'd0, 2'd0, 1'b0, 1);
      step();
    end
  endtask

  task automatic light_frame(input logic vis);
    sweep(389, 158, 162, vis, M_EA);
    sweep(390, 0, 170, vis, M_EA);
  endtask

  task automatic apply_tick(input logic [1:0] bank);
    h_cnt = 10'd0;
    v_cnt = 10'd480;
    push("apply", M_BR, 1'b0, 14'd0, bank, 1'b1, 1);
    step();
    h_cnt = 10'd1;
    step();
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] bank, input logic [1:0] cur_bank);
    h_cnt = 10'd50;
    v_cnt = 10'd100;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_banner = bank;
    push("cmd_accept", M_RD, 1'b0, 14'd0, 2'd0, 1'b0, 1);
    step();
    cmd_valid = 1'b0;
    h_cnt = 10'd51;
    push("bank_hold", M_BR, 1'b0, 14'd0, cur_bank, 1'b0, 1);
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    h_cnt = 10'd0;
    v_cnt = 10'd0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_banner = 2'd0;
    repeat (3) step();
    push("reset_init", M_ALL, 1'b0, 14'd0, 2'd0, 1'b1, 0);
    step();
    rst = 1'b0;
    step();

    // Show steady, bank 2: nothing before the apply line, then visible.
    light_frame(1'b0);
    issue(2'b01, 2'd2, 2'd0);
    apply_tick(2'd2);
    light_frame(1'b1);
    apply_tick(2'd2);

    // Full SHOW frame sweep.
    for (int v = 389; v <= 440; v++) sweep(v, 0, 481, 1'b1, M_EA);
    apply_tick(2'd2);

    // Hide during SHOW: the current frame stays visible, the next one is dark.
    issue(2'b00, 2'd1, 2'd2);
    light_frame(1'b1);
    apply_tick(2'd1);
    for (int v = 389; v <= 391; v++) sweep(v, 0, 481, 1'b0, M_EA);
    apply_tick(2'd1);

    // Blink with a 2-frame half period: on, on, off, off, on, on.
    issue(2'b10, 2'd3, 2'd1);
    light_frame(1'b0);
    apply_tick(2'd3);
    for (int f = 1; f <= 6; f++) begin
      light_frame((f == 1) || (f == 2) || (f == 5) || (f == 6));
      apply_tick(2'd3);
    end

    // Second command held across the apply cycle.
    issue(2'b01, 2'd0, 2'd3);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_banner = 2'd1;
    h_cnt = 10'd60;
    push("held_not_taken", M_RD, 1'b0, 14'd0, 2'd0, 1'b0, 1);
    step();
    light_frame(1'b0);
    h_cnt = 10'd0;
    v_cnt = 10'd480;
    push("held_apply_first", M_BR, 1'b0, 14'd0, 2'd0, 1'b1, 1);
    step();
    h_cnt = 10'd1;
    push("held_accept_second", M_BR, 1'b0, 14'd0, 2'd0, 1'b0, 1);
    step();
    cmd_valid = 1'b0;
    h_cnt = 10'd2;
    push("held_pending", M_BR, 1'b0, 14'd0, 2'd0, 1'b0, 1);
    step();
    light_frame(1'b1);
    apply_tick(2'd1);
    light_frame(1'b0);

    // Asynchronous reset in the middle of a visible banner.
    issue(2'b01, 2'd2, 2'd1);
    light_frame(1'b0);
    apply_tick(2'd2);
    sweep(389, 158, 162, 1'b1, M_EA);
    sweep(390, 0, 200, 1'b1, M_EA);
    h_cnt = 10'd201;
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    cmd_banner = 2'd3;
    push("midframe_accept", M_RD, 1'b0, 14'd0, 2'd0, 1'b0, 1);
    step();
    cmd_valid = 1'b0;
    h_cnt = 10'd202;
    step();
    h_cnt = 10'd203;
    rst = 1'b1;
    push("rst_async", M_ALL, 1'b0, 14'd0, 2'd0, 1'b1, 0);
    step();
    rst = 1'b0;
    sweep(390, 204, 300, 1'b0, M_EN);
    light_frame(1'b0);
    issue(2'b01, 2'd1, 2'd0);
    apply_tick(2'd1);
    light_frame(1'b1);

    repeat (3) step();
    if (q_cyc.size() > 0) begin
      $display("FAIL drain: %0d expectations never compared", q_cyc.size());
      n_checks += q_cyc.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
